// File: rtl/led_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_seq
// Description : Tick-stepped LED pattern generator (off/blink/chase/bounce)
//               with global PWM brightness dimming and registered LED drive.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_seq #(
    parameter int N_LEDS   = 8,
    parameter int PWM_BITS = 4
) (
    input  logic                mclk,
    input  logic                rs,
    input  logic                tick,
    input  logic [1:0]          mode,
    input  logic                mode_wr,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [N_LEDS-1:0]   pattern,
    output logic [N_LEDS-1:0]   led,
    output logic [15:0]         step_cnt
);

    localparam logic [1:0]          C_MODE_OFF    = 2'd0;
    localparam logic [1:0]          C_MODE_BLINK  = 2'd1;
    localparam logic [1:0]          C_MODE_CHASE  = 2'd2;
    localparam logic [1:0]          C_MODE_BOUNCE = 2'd3;
    localparam logic                C_DIR_LEFT    = 1'b0;
    localparam logic                C_DIR_RIGHT   = 1'b1;
    localparam logic [N_LEDS-1:0]   C_BIT0        = N_LEDS'(1);
    localparam logic [N_LEDS-1:0]   C_MSB         = {1'b1, {(N_LEDS-1){1'b0}}};
    localparam logic [N_LEDS-1:0]   C_ONES        = {N_LEDS{1'b1}};
    localparam logic [PWM_BITS-1:0] C_PWM_MAX     = {PWM_BITS{1'b1}};
    localparam logic [15:0]         C_STEP_MAX    = 16'hFFFF;

    logic [1:0]          r_mode;
    logic [N_LEDS-1:0]   r_pattern;
    logic                r_dir;
    logic [15:0]         r_step_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_bright;
    logic [N_LEDS-1:0]   r_led;

    logic [1:0]          w_mode_nxt;
    logic [N_LEDS-1:0]   w_pattern_nxt;
    logic                w_dir_nxt;
    logic [15:0]         w_step_nxt;
    logic                w_onehot;
    logic [N_LEDS-1:0]   w_shl;
    logic [N_LEDS-1:0]   w_shr;
    logic [N_LEDS-1:0]   w_rotl;
    logic                w_pwm_on;

    assign w_onehot = (r_pattern != '0) &&
                      ((r_pattern & (r_pattern - N_LEDS'(1))) == '0);
    assign w_shl    = r_pattern << 1;
    assign w_shr    = r_pattern >> 1;
    assign w_rotl   = {r_pattern[N_LEDS-2:0], r_pattern[N_LEDS-1]};

    // State register; brightness is only sampled at the PWM period boundary
    always_ff @(posedge mclk) begin
        if (rs) begin
            r_mode     <= C_MODE_OFF;
            r_pattern  <= '0;
            r_dir      <= C_DIR_LEFT;
            r_step_cnt <= '0;
            r_pwm_cnt  <= '0;
            r_bright   <= C_PWM_MAX;
            r_led      <= '0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_pattern  <= w_pattern_nxt;
            r_dir      <= w_dir_nxt;
            r_step_cnt <= w_step_nxt;
            r_pwm_cnt  <= r_pwm_cnt + PWM_BITS'(1);
            if (r_pwm_cnt == C_PWM_MAX) begin
                r_bright <= brightness;
            end
            r_led      <= r_pattern & {N_LEDS{w_pwm_on}};
        end
    end

    // Next-state logic: mode_wr takes precedence over a coincident tick
    always_comb begin
        w_mode_nxt    = r_mode;
        w_pattern_nxt = r_pattern;
        w_dir_nxt     = r_dir;
        w_step_nxt    = r_step_cnt;
        if (mode_wr) begin
            w_mode_nxt = mode;
            w_step_nxt = '0;
            w_dir_nxt  = C_DIR_LEFT;
            case (mode)
                C_MODE_OFF:   w_pattern_nxt = '0;
                C_MODE_BLINK: w_pattern_nxt = C_ONES;
                default:      w_pattern_nxt = C_BIT0;
            endcase
        end else if (tick) begin
            if (r_step_cnt != C_STEP_MAX) begin
                w_step_nxt = r_step_cnt + 16'd1;
            end
            case (r_mode)
                C_MODE_OFF:   w_pattern_nxt = '0;
                C_MODE_BLINK: w_pattern_nxt = ~r_pattern;
                C_MODE_CHASE: begin
                    if (!w_onehot) begin
                        w_pattern_nxt = C_BIT0;
                        w_dir_nxt     = C_DIR_LEFT;
                    end else begin
                        w_pattern_nxt = w_rotl;
                    end
                end
                C_MODE_BOUNCE: begin
                    if (!w_onehot) begin
                        w_pattern_nxt = C_BIT0;
                        w_dir_nxt     = C_DIR_LEFT;
                    end else if (r_dir == C_DIR_LEFT) begin
                        w_pattern_nxt = w_shl;
                        if (w_shl == C_MSB) begin
                            w_dir_nxt = C_DIR_RIGHT;
                        end
                    end else begin
                        w_pattern_nxt = w_shr;
                        if (w_shr == C_BIT0) begin
                            w_dir_nxt = C_DIR_LEFT;
                        end
                    end
                end
                default:      w_pattern_nxt = r_pattern;
            endcase
        end
    end

    // Full brightness bypasses the compare so the LED never drops a cycle
    always_comb begin
        w_pwm_on = (r_bright == C_PWM_MAX) || (r_pwm_cnt < r_bright);
    end

    assign pattern  = r_pattern;
    assign led      = r_led;
    assign step_cnt = r_step_cnt;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_seq
// Description : Directed self-checking bench for led_pattern_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_seq;

    logic        mclk;
    logic        rs;
    logic        tick;
    logic [1:0]  mode;
    logic        mode_wr;
    logic [3:0]  brightness;
    logic [7:0]  pattern;
    logic [7:0]  led;
    logic [15:0] step_cnt;

    int n_checks;
    int n_errors;
    logic [3:0] tb_pwm;

    led_pattern_seq #(.N_LEDS(8), .PWM_BITS(4)) dut (
        .mclk       (mclk),
        .rs         (rs),
        .tick       (tick),
        .mode       (mode),
        .mode_wr    (mode_wr),
        .brightness (brightness),
        .pattern    (pattern),
        .led        (led),
        .step_cnt   (step_cnt)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Reference PWM phase: value of the free-running counter after each edge
    always @(posedge mclk) begin
        if (rs) tb_pwm <= 4'd0;
        else    tb_pwm <= tb_pwm + 4'd1;
    end

    task automatic step();
        @(negedge mclk);
    endtask

    task automatic write_mode(input logic [1:0] m);
        mode = m; mode_wr = 1'b1;
        step();
        mode_wr = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rs = 1'b1; mode = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick = i[0]; mode_wr = ~i[0];
            step();
            n_checks++;
            if (pattern !== 8'h00 || led !== 8'h00 || step_cnt !== 16'd0) begin
                n_errors++;
                $display("FAIL reset_hold cyc=%0d: pattern=%h led=%h step_cnt=%0d, required 00/00/0",
                         i, pattern, led, step_cnt);
            end
        end
        rs = 1'b0; tick = 1'b0; mode_wr = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            n_checks++;
            if (led !== 8'h00) begin
                n_errors++;
                $display("FAIL reset_idle cyc=%0d: led=%h, required 00", i, led);
            end
        end
    endtask

    task automatic test_chase_wrap();
        logic [7:0] exp_tab [0:9];
        exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
        brightness = 4'hF;
        write_mode(2'd2);
        n_checks++;
        if (pattern !== exp_tab[0]) begin
            n_errors++;
            $display("FAIL chase_init: pattern=%h, required %h", pattern, exp_tab[0]);
        end
        for (int k = 1; k <= 9; k++) begin
            do_tick();
            n_checks++;
            if (pattern !== exp_tab[k] || led !== exp_tab[k-1]) begin
                n_errors++;
                $display("FAIL chase_step%0d: pattern=%h led=%h, required %h/%h",
                         k, pattern, led, exp_tab[k], exp_tab[k-1]);
            end
            step();
            n_checks++;
            if (led !== exp_tab[k]) begin
                n_errors++;
                $display("FAIL chase_led_lag%0d: led=%h, required %h", k, led, exp_tab[k]);
            end
            repeat (3) step();
        end
        n_checks++;
        if (step_cnt !== 16'd9) begin
            n_errors++;
            $display("FAIL chase_step_cnt: step_cnt=%0d, required 9", step_cnt);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] exp_tab [0:16];
        exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        write_mode(2'd3);
        for (int k = 1; k <= 16; k++) begin
            do_tick();
            step();
            n_checks++;
            if (pattern !== exp_tab[k]) begin
                n_errors++;
                $display("FAIL bounce_step%0d: pattern=%h, required %h", k, pattern, exp_tab[k]);
            end
        end
    endtask

    task automatic test_blink_collision();
        write_mode(2'd1);
        n_checks++;
        if (pattern !== 8'hFF) begin
            n_errors++;
            $display("FAIL blink_init: pattern=%h, required ff", pattern);
        end
        do_tick();
        n_checks++;
        if (pattern !== 8'h00 || step_cnt !== 16'd1) begin
            n_errors++;
            $display("FAIL blink_tick: pattern=%h step_cnt=%0d, required 00/1", pattern, step_cnt);
        end
        tick = 1'b1; mode = 2'd1; mode_wr = 1'b1;
        step();
        tick = 1'b0; mode_wr = 1'b0;
        n_checks++;
        if (pattern !== 8'hFF || step_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL blink_collision: pattern=%h step_cnt=%0d, required ff/0", pattern, step_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_tick();
        rs = 1'b1; tick = 1'b1;
        step();
        rs = 1'b0; tick = 1'b0;
        n_checks++;
        if (pattern !== 8'h00 || led !== 8'h00 || step_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_mid: pattern=%h led=%h step_cnt=%0d, required 00/00/0",
                     pattern, led, step_cnt);
        end
        do_tick();
        n_checks++;
        if (pattern !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_mode_off: pattern=%h, required 00", pattern);
        end
    endtask

    task automatic test_pwm_duty();
        logic [3:0] levels [0:2];
        int         exp_hi [0:2];
        int         hi;
        levels = '{4'd4, 4'd0, 4'hF};
        exp_hi = '{4, 0, 16};
        write_mode(2'd2);
        for (int j = 0; j < 3; j++) begin
            brightness = levels[j];
            repeat (32) step();
            hi = 0;
            for (int i = 0; i < 16; i++) begin
                step();
                if (led[0] === 1'b1) hi++;
            end
            n_checks++;
            if (hi !== exp_hi[j]) begin
                n_errors++;
                $display("FAIL pwm_duty b=%0d: high cycles=%0d, required %0d", levels[j], hi, exp_hi[j]);
            end
        end
    endtask

    task automatic test_pwm_boundary();
        int hi1;
        int hi2;
        int guard;
        brightness = 4'd4;
        repeat (32) step();
        guard = 0;
        while (tb_pwm !== 4'd0 && guard < 20) begin
            step();
            guard++;
        end
        n_checks++;
        if (tb_pwm !== 4'd0) begin
            n_errors++;
            $display("FAIL pwm_align: phase=%0d, required 0", tb_pwm);
        end
        hi1 = 0; hi2 = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == 5) brightness = 4'd12;
            step();
            if (led[0] === 1'b1) begin
                if (i < 16) hi1++;
                else        hi2++;
            end
        end
        n_checks++;
        if (hi1 !== 4) begin
            n_errors++;
            $display("FAIL pwm_boundary_cur: high cycles=%0d, required 4", hi1);
        end
        n_checks++;
        if (hi2 !== 12) begin
            n_errors++;
            $display("FAIL pwm_boundary_next: high cycles=%0d, required 12", hi2);
        end
    endtask

    task automatic test_saturation();
        brightness = 4'hF;
        write_mode(2'd1);
        tick = 1'b1;
        repeat (65540) step();
        tick = 1'b0;
        n_checks++;
        if (step_cnt !== 16'hFFFF || pattern !== 8'hFF) begin
            n_errors++;
            $display("FAIL saturation: step_cnt=%h pattern=%h, required ffff/ff", step_cnt, pattern);
        end
        write_mode(2'd1);
        n_checks++;
        if (step_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL saturation_clear: step_cnt=%h, required 0000", step_cnt);
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rs = 1'b1; tick = 1'b0; mode = 2'd0; mode_wr = 1'b0; brightness = 4'hF;
        step();
        test_reset();
        test_chase_wrap();
        test_bounce();
        test_blink_collision();
        test_reset_mid();
        test_pwm_duty();
        test_pwm_boundary();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
